// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Included by fetch_ctrl and program_counter via import fetch_pkg::*.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam int PC_INCR_DEFAULT = 4;

endpackage

// File: rtl/fetch_ctrl_pc.sv
// Program counter register for fetch_ctrl; the only way to change pc is a
// one-cycle pc_write pulse carrying pc_next.
module program_counter
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q <= '0;
    end else if (pc_write) begin
      pc_q <= pc_next;
    end
  end

  assign o_pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: BOOT/FETCH/FLUSH sequencing of imem requests.
// Optional trap input path enabled by defining FETCH_TRAP_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_INCR = PC_INCR_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
`ifdef FETCH_TRAP_EN
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vec,
`endif
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_instr
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(PC_INCR);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state_q;
  logic            req_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] pc;
  logic            redir_take;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic            pc_write;
  logic [XLEN-1:0] pc_next;

`ifdef FETCH_TRAP_EN
  assign redir_take = i_trap | i_redirect;
  assign raw_target = i_trap ? i_trap_vec : i_redirect_pc;
`else
  assign redir_take = i_redirect;
  assign raw_target = i_redirect_pc;
`endif

  assign target = raw_target & ALIGN_MASK;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= BOOT;
      req_q    <= 1'b0;
      target_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          // A redirect without a response must wait out the in-flight request.
          if (redir_take && !i_imem_ack) begin
            target_q <= target;
            state_q  <= FLUSH;
          end
        end
        FLUSH: begin
          if (i_imem_ack) begin
            state_q <= FETCH;
          end else if (redir_take) begin
            target_q <= target;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write = 1'b0;
    pc_next  = pc;
    if (i_imem_ack) begin
      if (state_q == FETCH) begin
        if (redir_take) begin
          pc_write = 1'b1;
          pc_next  = target;
        end else if (!i_stall) begin
          pc_write = 1'b1;
          pc_next  = pc + PC_STEP;
        end
      end else if (state_q == FLUSH) begin
        pc_write = 1'b1;
        pc_next  = redir_take ? target : target_q;
      end
    end
  end

  program_counter #(
    .XLEN(XLEN)
  ) u_pc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .pc_write  (pc_write),
    .pc_next   (pc_next),
    .o_pc      (pc)
  );

  assign o_imem_req  = req_q;
  assign o_imem_addr = pc;
  assign o_if_valid  = (state_q == FETCH) && i_imem_ack && !redir_take && !i_stall;
  assign o_if_pc     = pc;
  assign o_if_instr  = i_imem_rdata;

endmodule
